// File: rtl/riscv_exu_muldiv_pkg.sv
// Shared types for the M-extension multi-cycle execution unit.
// Op encoding follows funct3 so decode is a direct cast.
package riscv_exu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PRE,
        S_DIV_ITER,
        S_DIV_POST,
        S_FIN
    } muldiv_state_t;

    localparam int CNT_W = 16;

    function automatic int div_iters(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

endpackage

// File: rtl/riscv_exu_div_step.sv
// Combinational restoring-division step retiring BITS quotient bits.
// Partial remainder stays below the divisor, so XLEN+1 bits suffice.
module riscv_exu_div_step #(
    parameter int XLEN = 32,
    parameter int BITS = 1
) (
    input  logic [XLEN-1:0] rem,
    input  logic [BITS-1:0] dvd,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic [BITS-1:0] quo
);

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] r;

    always_comb begin
        r     = rem;
        trial = '0;
        quo   = '0;
        for (int i = BITS - 1; i >= 0; i--) begin
            trial = {r, dvd[i]} - {1'b0, dvs};
            if (!trial[XLEN]) begin
                r      = trial[XLEN-1:0];
                quo[i] = 1'b1;
            end else begin
                r = {r[XLEN-2:0], dvd[i]};
            end
        end
        rem_next = r;
    end

endmodule

// File: rtl/riscv_exu_muldiv.sv
// Multi-cycle M-extension unit: pipelined-latency multiplier and
// iterative restoring divider behind a valid/ready request port.
module riscv_exu_muldiv
    import riscv_exu_muldiv_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_LATENCY        = 2,
    parameter int DIV_BITS_PER_CYCLE = 1,
    parameter int TAG_W              = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             vld,
    output logic             rdy,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [4:0]       rd,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             register_write_en,
    output logic [4:0]       register_write,
    output logic [XLEN-1:0]  register_write_data,
    output logic [TAG_W-1:0] done_tag
);

    localparam int B        = DIV_BITS_PER_CYCLE;
    localparam int N        = div_iters(XLEN, B);
    localparam int MUL_LAST = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    muldiv_state_t state_q, state_n;
    muldiv_op_t    op_in;

    logic [1:0]        fn_q;
    logic [XLEN-1:0]   a_q, b_q, rem_q;
    logic [2*XLEN-1:0] prod_q, prod_c, a_ext, b_ext;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        rd_q, fin_rd;
    logic [TAG_W-1:0]  tag_q, fin_tag;
    logic              qneg_q, rneg_q;

    logic accept, is_div, div_zero, div_ovf, special, sa, sb, sgn, fin_go;
    logic [XLEN-1:0] a_mag, b_mag, spec_res, div_res, fin_data;
    logic [XLEN-1:0] step_rem_in, step_word, step_dvs, step_rem;
    logic [B-1:0]    step_q;

    function automatic logic [XLEN-1:0] mul_pick(
        input logic [1:0]        f,
        input logic [2*XLEN-1:0] p
    );
        return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign op_in    = muldiv_op_t'(op);
    assign accept   = vld && rdy && !flush;
    assign is_div   = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign div_zero = rs2_data == '0;
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM})
                   && rs1_data == {1'b1, {(XLEN-1){1'b0}}}
                   && rs2_data == '1;
    assign special  = is_div && (div_zero || div_ovf);
    assign spec_res = div_zero ? (op_in[1] ? rs1_data : '1)
                               : (op_in[1] ? '0 : rs1_data);

    // rs1 is signed except for MULHU, rs2 only for MUL/MULH
    assign sa     = op_in != OP_MULHU;
    assign sb     = op_in inside {OP_MUL, OP_MULH};
    assign a_ext  = {{XLEN{sa & rs1_data[XLEN-1]}}, rs1_data};
    assign b_ext  = {{XLEN{sb & rs2_data[XLEN-1]}}, rs2_data};
    assign prod_c = a_ext * b_ext;

    assign sgn   = !fn_q[0];
    assign a_mag = (sgn && a_q[XLEN-1]) ? -a_q : a_q;
    assign b_mag = (sgn && b_q[XLEN-1]) ? -b_q : b_q;

    // DIV_PRE already retires the first quotient bits from the magnitudes
    assign step_rem_in = (state_q == S_DIV_PRE) ? '0 : rem_q;
    assign step_word   = (state_q == S_DIV_PRE) ? a_mag : a_q;
    assign step_dvs    = (state_q == S_DIV_PRE) ? b_mag : b_q;

    riscv_exu_div_step #(
        .XLEN (XLEN),
        .BITS (B)
    ) u_div_step (
        .rem      (step_rem_in),
        .dvd      (step_word[XLEN-1 -: B]),
        .dvs      (step_dvs),
        .rem_next (step_rem),
        .quo      (step_q)
    );

    assign div_res = fn_q[1] ? (rneg_q ? -rem_q : rem_q)
                             : (qneg_q ? -a_q : a_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (special || (!is_div && MUL_LATENCY == 1)) begin
                        state_n = S_FIN;
                    end else if (is_div) begin
                        state_n = S_DIV_PRE;
                    end else begin
                        state_n = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_W'(MUL_LAST)) state_n = S_FIN;
            end
            S_DIV_PRE:  state_n = S_DIV_ITER;
            S_DIV_ITER: begin
                if (cnt_q == CNT_W'(N - 1)) state_n = S_DIV_POST;
            end
            S_DIV_POST: state_n = S_FIN;
            S_FIN:      state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
        if (flush && state_q != S_IDLE) state_n = S_IDLE;
    end

    always_comb begin
        rdy  = state_q == S_IDLE;
        busy = state_q != S_IDLE;
    end

    always_comb begin
        fin_data = '0;
        fin_rd   = rd_q;
        fin_tag  = tag_q;
        unique case (state_q)
            S_IDLE: begin
                fin_rd   = rd;
                fin_tag  = tag;
                fin_data = is_div ? spec_res : mul_pick(op[1:0], prod_c);
            end
            S_MUL:      fin_data = mul_pick(fn_q, prod_q);
            S_DIV_POST: fin_data = div_res;
            default:    fin_data = '0;
        endcase
    end

    assign fin_go = state_n == S_FIN;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fn_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
            tag_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            if (accept) begin
                fn_q   <= op[1:0];
                a_q    <= rs1_data;
                b_q    <= rs2_data;
                rd_q   <= rd;
                tag_q  <= tag;
                prod_q <= prod_c;
            end
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
            end else if (state_q inside {S_MUL, S_DIV_PRE, S_DIV_ITER}) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_DIV_PRE) begin
                b_q    <= b_mag;
                qneg_q <= sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                rneg_q <= sgn && a_q[XLEN-1];
            end
            if (state_q inside {S_DIV_PRE, S_DIV_ITER}) begin
                a_q   <= {step_word[XLEN-B-1:0], step_q};
                rem_q <= step_rem;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done                <= 1'b0;
            register_write_en   <= 1'b0;
            register_write      <= '0;
            register_write_data <= '0;
            done_tag            <= '0;
        end else begin
            done              <= fin_go;
            register_write_en <= fin_go && fin_rd != 5'd0;
            if (fin_go) begin
                register_write      <= fin_rd;
                register_write_data <= (fin_rd != 5'd0) ? fin_data : '0;
                done_tag            <= fin_tag;
            end
        end
    end

endmodule
